uart_cmd_wrapper: RTL and testbench

- Serial front end of the flight controller. Receives 3-byte command frames from the BLE module on `RX`: command byte, data high byte, data low byte.
- Presents each completed frame as `cmd`/`data` with a held `cmd_rdy` flag to the command-config unit.
- Serializes single response bytes from the command-config unit onto `TX`.
- Contains its own 8N1 receive and transmit engines.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_trcv.sv | 158 +++++++++++++++
 rtl/uart_cmd_wrapper.sv | 107 ++++++++++
 tb/tb_uart_cmd_wrapper.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the BLE command UART.
// Engine state encodings and frame geometry used by the wrapper and the bit engines.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        ASM_B1,
        ASM_B2,
        ASM_B3
    } asm_state_t;

    localparam int FRAME_BYTES    = 3;
    localparam int BITS_PER_FRAME = 10;
    localparam int DEF_BAUD_DIV   = 2604;

endpackage

// File: rtl/uart_trcv.sv
// 8N1 receive and transmit bit engines with independent saturating baud counters.
// RX strobes (rx_vld/rx_ferr) are combinational and valid only in the stop-sample cycle.
module uart_trcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_vld,
    output logic [7:0] rx_byte,
    output logic       rx_ferr,
    output logic       rx_busy,
    input  logic       trmt,
    input  logic [7:0] tx_byte,
    output logic       tx_done,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]    LAST_BIT = 4'(BITS_PER_FRAME - 1);

    // ---------------- receive ----------------
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_fall, rx_half, rx_full;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_half = (rx_cnt == HALF);
    assign rx_full = (rx_cnt == FULL);
    assign rx_byte = rx_shift;
    assign rx_busy = (rx_state != RX_IDLE);

    // Synchronizer and edge-detect history preset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        rx_vld  = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_full) begin
                    rx_next = RX_IDLE;
                    rx_vld  = rx_s2;
                    rx_ferr = ~rx_s2;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state != rx_next || (rx_state == RX_DATA && rx_full))
                rx_cnt <= '0;
            else if (!rx_full)
                rx_cnt <= rx_cnt + 1'b1;

            if (rx_state == RX_START)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_full) begin
                rx_bit   <= rx_bit + 1'b1;
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end
        end
    end

    // ---------------- transmit ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_nbit;
    logic [9:0]    tx_shift;
    logic          tx_full, tx_load, tx_last;

    assign tx_full = (tx_cnt == FULL);
    assign tx      = tx_shift[0];

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_last = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    tx_next = TX_SHIFT;
                    tx_load = 1'b1;
                end
            end
            TX_SHIFT: begin
                if (tx_full && tx_nbit == LAST_BIT) begin
                    tx_next = TX_IDLE;
                    tx_last = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Shifting in ones leaves the line high once the stop bit has gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_nbit  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= tx_last;
            if (tx_load) begin
                tx_shift <= {1'b1, tx_byte, 1'b0};
                tx_cnt   <= '0;
                tx_nbit  <= '0;
            end else if (tx_state == TX_SHIFT) begin
                if (tx_full) begin
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_cnt   <= '0;
                    tx_nbit  <= tx_nbit + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// BLE command front end: assembles 3-byte frames into cmd/data with a held ready flag
// and serializes single response bytes.
module uart_cmd_wrapper
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT_CYC);

    logic       rx_vld, rx_ferr, rx_busy;
    logic [7:0] rx_byte;

    uart_trcv #(.BAUD_DIV(BAUD_DIV)) u_trcv (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .rx_vld  (rx_vld),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy),
        .trmt    (send_resp),
        .tx_byte (resp),
        .tx_done (resp_sent),
        .tx      (TX)
    );

    asm_state_t    asm_state, asm_next;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    stage_cmd, stage_hi;
    logic          frame_done, timed_out;

    assign timed_out = (asm_state != ASM_B1) && (idle_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) asm_state <= ASM_B1;
        else     asm_state <= asm_next;
    end

    always_comb begin
        asm_next   = asm_state;
        frame_done = 1'b0;
        if (rx_ferr) begin
            asm_next = ASM_B1;
        end else if (rx_vld) begin
            case (asm_state)
                ASM_B1:  asm_next = ASM_B2;
                ASM_B2:  asm_next = ASM_B3;
                ASM_B3: begin
                    asm_next   = ASM_B1;
                    frame_done = 1'b1;
                end
                default: asm_next = ASM_B1;
            endcase
        end else if (timed_out) begin
            asm_next = ASM_B1;
        end
    end

    // Idle time only accrues between bytes; any byte in flight holds the counter at zero.
    always_ff @(posedge clk) begin
        if (rst || asm_state == ASM_B1 || rx_busy)
            idle_cnt <= '0;
        else if (idle_cnt != TO_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_cmd <= '0;
            stage_hi  <= '0;
        end else if (rx_vld) begin
            if (asm_state == ASM_B1) stage_cmd <= rx_byte;
            if (asm_state == ASM_B2) stage_hi  <= rx_byte;
        end
    end

    // Completion outranks a same-cycle clear so a fresh frame is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= '0;
            data    <= '0;
            cmd_rdy <= 1'b0;
        end else if (frame_done) begin
            cmd     <= stage_cmd;
            data    <= {stage_hi, rx_byte};
            cmd_rdy <= 1'b1;
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper at BAUD_DIV=16, TIMEOUT_CYC=400.
module tb_uart_cmd_wrapper;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rise_cyc = -1;
    int   s;
    logic rdy_q = 1'b0;
    logic [9:0] tf;

    uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(400)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_rdy && !rdy_q) rise_cyc = cyc;
        rdy_q = cmd_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            step(BD);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
    endtask

    initial begin
        step(3);
        chk("rst_tx", TX, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_data", data, 0);
        chk("rst_rdy", cmd_rdy, 0);
        chk("rst_sent", resp_sent, 0);
        rst = 1'b0;
        step(5);

        // Frame decode and exact ready timing: stop sample of byte 3 lands 155 edges into it.
        s = cyc;
        send_frame(8'h05, 8'h12, 8'h34);
        chk("dec_rise", rise_cyc, s + 475);
        chk("dec_rdy", cmd_rdy, 1);
        chk("dec_cmd", cmd, 8'h05);
        chk("dec_data", data, 16'h1234);
        step(7);
        chk("dec_hold", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        chk("dec_clr", cmd_rdy, 0);
        chk("dec_cmd_keep", cmd, 8'h05);

        // Response transmit, second request during shift ignored.
        tf = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        send_resp = 1'b1;
        step(1);
        send_resp = 1'b0;
        for (int j = 0; j < 11 * BD; j++) begin
            chk("tx_bit", TX, (j < 10 * BD) ? tf[j / BD] : 1'b1);
            chk("tx_sent", resp_sent, (j == 10 * BD) ? 1 : 0);
            if (j == 39) begin
                resp = 8'hFF;
                send_resp = 1'b1;
            end
            if (j == 40) send_resp = 1'b0;
            step(1);
        end

        // Framing error on byte 2 discards the partial frame.
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        RX = 1'b1;
        step(40);
        chk("ferr_no_rdy", cmd_rdy, 0);
        send_frame(8'h02, 8'hFF, 8'h00);
        chk("ferr_rdy", cmd_rdy, 1);
        chk("ferr_cmd", cmd, 8'h02);
        chk("ferr_data", data, 16'hFF00);

        // Clear in the completion cycle of a frame that overwrites a pending one.
        s = cyc;
        fork
            send_frame(8'h07, 8'h00, 8'h02);
            begin
                while (cyc < s + 474) step(1);
                clr_cmd_rdy = 1'b1;
                step(1);
                clr_cmd_rdy = 1'b0;
            end
        join
        chk("col_rdy", cmd_rdy, 1);
        chk("col_cmd", cmd, 8'h07);
        chk("col_data", data, 16'h0002);
        clr_cmd_rdy = 1'b1;
        step(1);
        clr_cmd_rdy = 1'b0;
        chk("col_clr", cmd_rdy, 0);

        // Inter-byte timeout drops the stale bytes.
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        RX = 1'b1;
        step(500);
        chk("to_no_rdy", cmd_rdy, 0);
        send_frame(8'h06, 8'h00, 8'h01);
        chk("to_rdy", cmd_rdy, 1);
        chk("to_cmd", cmd, 8'h06);
        chk("to_data", data, 16'h0001);

        // Reset mid RX byte 2 and mid TX bit 4.
        send_byte(8'h11, 1'b1);
        resp = 8'h00;
        send_resp = 1'b1;
        RX = 1'b0;
        step(1);
        send_resp = 1'b0;
        step(69);
        chk("rst_pre_tx", TX, 0);
        rst = 1'b1;
        RX = 1'b1;
        step(1);
        chk("mrst_tx", TX, 1);
        chk("mrst_rdy", cmd_rdy, 0);
        chk("mrst_cmd", cmd, 0);
        chk("mrst_data", data, 0);
        chk("mrst_sent", resp_sent, 0);
        rst = 1'b0;
        step(30);
        send_frame(8'h09, 8'hAB, 8'hCD);
        chk("post_rdy", cmd_rdy, 1);
        chk("post_cmd", cmd, 8'h09);
        chk("post_data", data, 16'hABCD);
        chk("post_tx", TX, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
